// File: rtl/bit_serial_adder_ctrl_if.sv
// Handshake and data bundle for the bit-serial adder sequencer.
// The master drives the request and operands; the slave returns status, the result and its FSM state.
interface bit_serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    // start is sampled only while the sequencer is idle. A start seen in IDLE is
    // accepted on that edge, and a, b and c_in are captured on the same edge.
    // busy is high while the sequencer runs. done is high for exactly one cycle,
    // and sum and c_out are valid from that cycle until the next completion.
    // Back-pressure is not needed: a start that arrives while busy or done is dropped.
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic [1:0]       state_dbg;

    modport master (
        output start, a, b, c_in,
        input  busy, done, sum, c_out, state_dbg
    );

    modport slave (
        input  start, a, b, c_in,
        output busy, done, sum, c_out, state_dbg
    );
endinterface

// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial adder: one shared full-adder cell adds two WIDTH-bit operands plus carry-in,
// one bit per clock, LSB first. The result is then held until the next completion.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic z,
    output logic c_out
);
    assign z     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module bit_serial_adder_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bit_serial_adder_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sh_a, sh_b, sh_s, sh_s_nxt;
    logic [WIDTH-1:0] sum_q;
    logic             carry, c_out_q;
    logic [CNT_W-1:0] cnt;
    logic             cell_z, cell_c;
    logic             last_bit;
    logic             busy_c, done_c;

    full_adder_cell u_cell (
        .a     (sh_a[0]),
        .b     (sh_b[0]),
        .c_in  (carry),
        .z     (cell_z),
        .c_out (cell_c)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // Each new sum bit enters at the MSB, so after WIDTH shifts the word is aligned.
    always_comb begin
        sh_s_nxt            = sh_s >> 1;
        sh_s_nxt[WIDTH-1]   = cell_z;
    end

    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            S_IDLE: if (bus.start) state_nxt = S_RUN;
            S_RUN: begin
                busy_c = 1'b1;
                if (last_bit) state_nxt = S_DONE;
            end
            S_DONE: begin
                done_c    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a    <= '0;
            sh_b    <= '0;
            sh_s    <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else if (state == S_IDLE && bus.start) begin
            sh_a  <= bus.a;
            sh_b  <= bus.b;
            sh_s  <= '0;
            carry <= bus.c_in;
            cnt   <= '0;
        end else if (state == S_RUN) begin
            sh_a  <= sh_a >> 1;
            sh_b  <= sh_b >> 1;
            sh_s  <= sh_s_nxt;
            carry <= cell_c;
            cnt   <= cnt + CNT_W'(1);
            // Published outputs change only here, so they hold across IDLE and the next RUN.
            if (last_bit) begin
                sum_q   <= sh_s_nxt;
                c_out_q <= cell_c;
            end
        end
    end

    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Directed bench for bit_serial_adder_ctrl: WIDTH=8 and WIDTH=1 instances on one clock,
// with results predicted into queues at start time and checked when done pulses.
module tb_bit_serial_adder_ctrl;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  int   cyc;
  int   start_cyc;
  int   busy_run8;
  logic [8:0] last_res8;
  logic [8:0] exp_q8[$];
  logic [1:0] exp_q1[$];

  bit_serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
  bit_serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();

  bit_serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  bit_serial_adder_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus8.busy === 1'b1) busy_run8++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    bus8.a     = a;
    bus8.b     = b;
    bus8.c_in  = cin;
    bus8.start = 1'b1;
    busy_run8  = 0;
    exp_q8.push_back(9'(a) + 9'(b) + 9'(cin));
    tick();
    start_cyc  = cyc;
    bus8.start = 1'b0;
  endtask

  // scoreboard: waits (bounded) for done, checks latency, busy length, result, pulse width
  task automatic wait_done8(input string tag);
    int guard;
    logic [8:0] exp;
    guard = 0;
    while (bus8.done !== 1'b1 && guard < 40) begin
      check({tag, "_hold"}, 32'({bus8.c_out, bus8.sum}), 32'(last_res8));
      tick();
      guard++;
    end
    check({tag, "_done"}, 32'(bus8.done), 32'd1);
    check({tag, "_lat"}, 32'(cyc - start_cyc), 32'd8);
    check({tag, "_busy_len"}, 32'(busy_run8), 32'd8);
    check({tag, "_busy_in_done"}, 32'(bus8.busy), 32'd0);
    check({tag, "_q_nonempty"}, 32'(exp_q8.size() > 0), 32'd1);
    if (exp_q8.size() > 0) begin
      exp = exp_q8.pop_front();
      check({tag, "_result"}, 32'({bus8.c_out, bus8.sum}), 32'(exp));
      last_res8 = exp;
    end
    tick();
    check({tag, "_pulse_end"}, 32'(bus8.done), 32'd0);
  endtask

  initial begin
    int extra;
    n_cmp = 0; n_fail = 0; cyc = 0; start_cyc = 0; busy_run8 = 0;
    last_res8 = '0;
    rst_n = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.c_in = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.c_in = 1'b0;
    #1;
    check("rst_busy", 32'(bus8.busy), 32'd0);
    check("rst_done", 32'(bus8.done), 32'd0);
    check("rst_result", 32'({bus8.c_out, bus8.sum}), 32'd0);
    check("rst_state", 32'(bus8.state_dbg), 32'd0);
    check("rst_w1_result", 32'({bus1.c_out, bus1.sum}), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 1: basic add
    start_op8(8'h35, 8'h4A, 1'b0);
    check("t1_busy_first", 32'(bus8.busy), 32'd1);
    check("t1_state_run", 32'(bus8.state_dbg), 32'd1);
    wait_done8("t1");

    // 2: wrap-around and all-ones with carry-in
    start_op8(8'hFF, 8'h01, 1'b0);
    wait_done8("t2a");
    start_op8(8'hFF, 8'hFF, 1'b1);
    wait_done8("t2b");

    // 5: reset mid-operation discards the partial result
    start_op8(8'h12, 8'h34, 1'b0);
    tick();
    tick();
    void'(exp_q8.pop_back());
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 32'(bus8.busy), 32'd0);
    check("t5_rst_done", 32'(bus8.done), 32'd0);
    check("t5_rst_result", 32'({bus8.c_out, bus8.sum}), 32'd0);
    check("t5_rst_state", 32'(bus8.state_dbg), 32'd0);
    last_res8 = '0;
    tick();
    tick();
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus8.done === 1'b1 || bus8.busy === 1'b1) extra++;
    end
    check("t5_no_done_after_rst", 32'(extra), 32'd0);
    start_op8(8'h12, 8'h34, 1'b0);
    wait_done8("t5");

    // 3: operand isolation and ignored starts during RUN
    start_op8(8'h0F, 8'h01, 1'b0);
    tick();
    bus8.a = 8'hAA; bus8.b = 8'h55; bus8.c_in = 1'b1;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    tick();
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    wait_done8("t3");
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus8.done === 1'b1 || bus8.busy === 1'b1) extra++;
    end
    check("t3_no_extra_op", 32'(extra), 32'd0);
    check("t3_queue_empty", 32'(exp_q8.size()), 32'd0);

    // 4: level-held start gives back-to-back operations
    bus8.a = 8'h80; bus8.b = 8'h80; bus8.c_in = 1'b0;
    bus8.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      busy_run8 = 0;
      exp_q8.push_back(9'h100);
      tick();
      if (k > 0) check("t4_spacing", 32'(cyc - start_cyc), 32'd10);
      start_cyc = cyc;
      wait_done8("t4");
    end
    bus8.start = 1'b0;
    tick();
    tick();
    check("t4_idle_busy", 32'(bus8.busy), 32'd0);
    check("t4_result_held", 32'({bus8.c_out, bus8.sum}), 32'h100);

    // 6: WIDTH=1 instance, exhaustive
    for (int i = 0; i < 8; i++) begin
      bus1.a = i[2]; bus1.b = i[1]; bus1.c_in = i[0];
      bus1.start = 1'b1;
      exp_q1.push_back(2'(i[2]) + 2'(i[1]) + 2'(i[0]));
      tick();
      bus1.start = 1'b0;
      check("t6_busy", 32'(bus1.busy), 32'd1);
      check("t6_not_done", 32'(bus1.done), 32'd0);
      tick();
      check("t6_done", 32'(bus1.done), 32'd1);
      if (exp_q1.size() > 0) check("t6_result", 32'({bus1.c_out, bus1.sum}), 32'(exp_q1.pop_front()));
      tick();
      check("t6_pulse_end", 32'(bus1.done), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/bit_serial_adder_ctrl.md
Name: bit_serial_adder_ctrl

Overview:
- Sequencer that time-shares one 1-bit full-adder cell to add two WIDTH-bit operands plus carry-in, one bit per clock, LSB first.
- The cell is the gate-level sum/carry structure: z = a^b^c_in, c_out = a&b | c_in&(a^b). It is instantiated once inside this block.
- This block owns operand capture, the carry register, bit counting, result assembly and the start/busy/done handshake.
- It is the first sequential wrapper around the team's combinational adder cell.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, do not override.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset; release is synchronous to clk.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- c_in  input  1  carry-in; captured on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  registered result, bits [WIDTH-1:0] of a+b+c_in.
- c_out  output  1  registered final carry, bit WIDTH of a+b+c_in.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset (rst_n=0), applied immediately with no clock needed:
  - state=IDLE; busy=0; done=0; sum=0; c_out=0.
  - Internal shift registers, carry register and counter all cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge: capture a, b, c_in into shA, shB and carry; cnt=0; go to RUN.
  - start=0: stay in IDLE.
- RUN (busy=1):
  - Each edge feeds cell inputs shA[0], shB[0], carry.
  - Cell z shifts into the MSB of shS; shS, shA and shB shift right by 1.
  - carry <= cell c_out; cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1: load sum<=final shS, c_out<=final carry; go to DONE.
- DONE:
  - done=1, busy=0 for exactly one cycle.
  - Next edge goes unconditionally to IDLE.
  - start is ignored in DONE.
- Latency:
  - start accepted at edge E0; done is high in the cycle following edge E_WIDTH.
  - So done rises exactly WIDTH clocks after the accepting edge.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- Output holding: sum and c_out update only on the RUN->DONE edge. They hold the last result through IDLE and the next RUN until the next completion.
- Operand isolation: changes on a, b, c_in after capture have no effect on the in-flight operation.
- start during RUN or DONE: ignored, not queued. A level-held start is re-accepted on the first IDLE edge.
- Reset mid-operation: abort immediately with no done pulse; outputs go to reset values; the partial result is discarded.
- WIDTH=1: RUN lasts exactly one cycle; behaviour otherwise identical.
- Arithmetic: unsigned. {c_out,sum} == a+b+c_in computed at WIDTH+1 bits; wrap-around appears only as c_out=1.

Test Plan:
1. WIDTH=8, a=8'h35, b=8'h4A, c_in=0, one-cycle start:
   - busy high 8 cycles, then done pulse exactly 8 clocks after the accepting edge.
   - sum=8'h7F, c_out=0.
2. a=8'hFF, b=8'h01, c_in=0 -> sum=8'h00, c_out=1. Then a=8'hFF, b=8'hFF, c_in=1 -> sum=8'hFF, c_out=1. done pulses exactly one cycle each.
3. Start a=8'h0F, b=8'h01, c_in=0, then during RUN change a/b to 8'hAA/8'h55 and pulse start twice -> result sum=8'h10, c_out=0. No extra operation occurs; done pulses once.
4. Hold start high continuously for a=8'h80, b=8'h80 -> back-to-back operations spaced WIDTH+2 cycles, each sum=8'h00, c_out=1. Between results, sum/c_out stay stable.
5. Start a=8'h12, b=8'h34, then assert rst_n=0 after 3 RUN cycles -> busy, done, sum, c_out go to 0 without a clock edge, and no done follows. After release, a=8'h12, b=8'h34 gives sum=8'h46, c_out=0.
6. WIDTH=1 build, all 8 combinations of a, b, c_in -> {c_out,sum} equals a+b+c_in, with done one cycle after the accepting edge.
